// File: rtl/router_out_drain_if.sv
// Bus between the router output FIFO, the drain logic and the destination port.
// The drain block itself is the master: it drives the read strobe, the flush
// pulse and the outgoing byte stream; FIFO flags and dout_ready come back in.
interface router_out_drain_if;
  logic       fifo_empty;
  logic [8:0] fifo_data_out;
  logic       fifo_read_enb;
  logic       soft_reset;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_first;
  logic       dout_last;
  logic [1:0] pkt_addr;
  logic       frame_err;
  logic       parity_err;

  modport master (
    input  fifo_empty, fifo_data_out, dout_ready,
    output fifo_read_enb, soft_reset, dout, dout_valid, dout_first,
           dout_last, pkt_addr, frame_err, parity_err
  );

  modport slave (
    output fifo_empty, fifo_data_out, dout_ready,
    input  fifo_read_enb, soft_reset, dout, dout_valid, dout_first,
           dout_last, pkt_addr, frame_err, parity_err
  );
endinterface

// File: rtl/router_out_drain.sv
// Reader side of a router output FIFO: pulls one 9-bit entry at a time,
// checks header/payload/parity framing, and hands bytes to the destination
// over valid/ready. A destination that stalls for TIMEOUT cycles gets the
// packet abandoned and the FIFO flushed through soft_reset.
module router_out_drain #(
  parameter int unsigned TIMEOUT   = 30,   // 1..255 stalled cycles
  parameter bit          PAR_CHECK = 1'b1
) (
  input logic              clk,
  input logic              reset,
  router_out_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_e;
  // What the next captured FIFO entry must be.
  typedef enum logic [1:0] {EXP_HDR, EXP_PAY, EXP_PAR} expect_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q;
  expect_e    exp_q;
  logic [5:0] rem_q;
  logic [7:0] acc_q;
  logic [7:0] tmo_q;
  logic [7:0] dout_q;
  logic       valid_q;
  logic       first_q;
  logic       last_q;
  logic [1:0] addr_q;
  logic       frame_err_q;
  logic       parity_err_q;

  logic       hdr_bit;
  logic [7:0] byte_in;
  logic       capt_ok;
  logic       stall;
  logic       tmo_hit;

  // Classify the entry on the FIFO read port: a header marker is only legal
  // when a header is expected, and illegal everywhere else.
  assign hdr_bit = bus.fifo_data_out[8];
  assign byte_in = bus.fifo_data_out[7:0];
  assign capt_ok = ((exp_q == EXP_HDR) == hdr_bit);

  assign stall   = (state_q == SEND) && !bus.dout_ready;
  assign tmo_hit = stall && (tmo_q == TMO_LAST);

  // NOTE: the read strobe and the flush pulse are decoded from state plus the
  // live fifo_empty / dout_ready inputs rather than registered: the strobe
  // must never fire on an empty FIFO, and a late dout_ready on the final
  // stalled cycle must still cancel the flush in that same cycle.
  assign bus.fifo_read_enb = !reset && (state_q == READ) && !bus.fifo_empty;
  assign bus.soft_reset    = !reset && tmo_hit;

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_first = first_q;
  assign bus.dout_last  = last_q;
  assign bus.pkt_addr   = addr_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;

  // Main FSM: fetch, capture/classify, present, with registered outputs.
  // NOTE: every register here, including the datapath, is cleared by reset so
  // a packet interrupted mid-flight leaves no stale length or parity behind;
  // all state updates are non-blocking so the case arms read pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      exp_q        <= EXP_HDR;
      rem_q        <= '0;
      acc_q        <= '0;
      tmo_q        <= '0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!bus.fifo_empty) state_q <= READ;
        end
        READ: begin
          // An underrun mid-packet simply waits here; no timeout applies.
          if (!bus.fifo_empty) state_q <= CAPT;
        end
        CAPT: begin
          if (!capt_ok) begin
            // Bad framing: drop the entry and resynchronise on a new header.
            frame_err_q <= 1'b1;
            exp_q       <= EXP_HDR;
            state_q     <= IDLE;
          end else begin
            dout_q  <= byte_in;
            valid_q <= 1'b1;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= SEND;
            unique case (exp_q)
              EXP_HDR: begin
                first_q <= 1'b1;
                rem_q   <= byte_in[7:2];
                addr_q  <= byte_in[1:0];
                acc_q   <= byte_in;
                exp_q   <= (byte_in[7:2] == 6'd0) ? EXP_PAR : EXP_PAY;
              end
              EXP_PAY: begin
                acc_q <= acc_q ^ byte_in;
                rem_q <= rem_q - 6'd1;
                exp_q <= (rem_q == 6'd1) ? EXP_PAR : EXP_PAY;
              end
              default: begin
                last_q       <= 1'b1;
                parity_err_q <= PAR_CHECK && (byte_in != acc_q);
                exp_q        <= EXP_HDR;
              end
            endcase
          end
        end
        SEND: begin
          if (bus.dout_ready) begin
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            tmo_q   <= '0;
            state_q <= last_q ? IDLE : READ;
          end else if (tmo_hit) begin
            // Destination gone: abandon the packet, the FIFO is flushed.
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            tmo_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            exp_q   <= EXP_HDR;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_drain.sv
// Directed bench for router_out_drain: a small FIFO model feeds two instances
// (PAR_CHECK=1 and PAR_CHECK=0) in lockstep; a monitor logs accepted bytes
// and pulse counts, and the main sequence checks them against hand values.
module tb_router_out_drain;

  logic clk;
  logic reset;

  router_out_drain_if bus0 ();
  router_out_drain_if bus1 ();

  router_out_drain dut0 (.clk(clk), .reset(reset), .bus(bus0));
  router_out_drain #(.PAR_CHECK(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: written by the stimulus, popped by dut0's strobe.
  logic [8:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus0.fifo_empty = (wr_ptr == rd_ptr);
  assign bus1.fifo_empty    = bus0.fifo_empty;
  assign bus1.fifo_data_out = bus0.fifo_data_out;
  assign bus1.dout_ready    = bus0.dout_ready;

  always @(posedge clk) begin
    if (reset || bus0.soft_reset) begin
      rd_ptr             <= wr_ptr;
      bus0.fifo_data_out <= '0;
    end else if (bus0.fifo_read_enb) begin
      bus0.fifo_data_out <= mem[rd_ptr % 64];
      rd_ptr             <= rd_ptr + 1;
    end
  end

  // Monitor: sampled mid-low-phase, after the stimulus has settled.
  int mcyc = 0;
  int rd_cnt = 0, soft_cnt = 0, frame_cnt = 0, par_cnt = 0, par_aligned = 0, par1_cnt = 0;
  logic prev_valid = 1'b0;
  logic [9:0] acc_q [$];
  int acc_cyc [$];

  always @(negedge clk) begin
    #3;
    mcyc++;
    if (bus0.fifo_read_enb) rd_cnt++;
    if (bus0.soft_reset) soft_cnt++;
    if (bus0.frame_err) frame_cnt++;
    if (bus0.parity_err) par_cnt++;
    if (bus0.parity_err && bus0.dout_valid && !prev_valid) par_aligned++;
    if (bus1.parity_err) par1_cnt++;
    if (bus0.dout_valid && bus0.dout_ready) begin
      acc_q.push_back({bus0.dout_first, bus0.dout_last, bus0.dout});
      acc_cyc.push_back(mcyc);
    end
    prev_valid = bus0.dout_valid;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_b [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr++;
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    int n = 0;
    while (acc_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, acc_q.size(), target);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus0.dout_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, bus0.dout_valid}, 32'd1);
  endtask

  // Compare n accepted bytes from index base with exp_b; first/last flags
  // are expected on the first and final byte of the packet.
  task automatic check_pkt(input string tag, input int base, input int n, input bit thr);
    logic [9:0] obs;
    for (int i = 0; i < n; i++) begin
      obs = (base + i < acc_q.size()) ? acc_q[base + i] : 10'bx;
      check($sformatf("%s_byte%0d", tag, i), {22'd0, obs},
            {22'd0, (i == 0), (i == n - 1), exp_b[i]});
      if (thr && i > 0 && base + i < acc_cyc.size())
        check($sformatf("%s_gap%0d", tag, i), acc_cyc[base + i] - acc_cyc[base + i - 1], 3);
    end
  endtask

  initial begin
    int base, rd0, soft0, frame0, par0, par10, al0;

    reset = 1'b1;
    bus0.dout_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_valid", {31'd0, bus0.dout_valid}, 0);
    check("rst_rd",    {31'd0, bus0.fifo_read_enb}, 0);
    check("rst_soft",  {31'd0, bus0.soft_reset}, 0);
    check("rst_addr",  {30'd0, bus0.pkt_addr}, 0);
    check("rst_dout",  {24'd0, bus0.dout}, 0);
    check("rst_first", {31'd0, bus0.dout_first}, 0);
    reset = 1'b0;
    bus0.dout_ready = 1'b1;
    tick();

    // Nominal packet, addr 1, len 3, good parity.
    base = acc_q.size(); rd0 = rd_cnt; frame0 = frame_cnt; par0 = par_cnt;
    push(9'h10D); push(9'h0AA); push(9'h055); push(9'h00F); push(9'h0FD);
    wait_acc("nom_wait", base + 5, 60);
    exp_b[0] = 8'h0D; exp_b[1] = 8'hAA; exp_b[2] = 8'h55; exp_b[3] = 8'h0F; exp_b[4] = 8'hFD;
    check_pkt("nom", base, 5, 1'b1);
    repeat (4) tick();
    check("nom_addr",  {30'd0, bus0.pkt_addr}, 1);
    check("nom_reads", rd_cnt - rd0, 5);
    check("nom_frame", frame_cnt - frame0, 0);
    check("nom_par",   par_cnt - par0, 0);
    check("nom_idle",  {31'd0, bus0.dout_valid}, 0);

    // Bad parity byte: forwarded, flagged only by the checking instance.
    base = acc_q.size(); par0 = par_cnt; par10 = par1_cnt; al0 = par_aligned;
    push(9'h10D); push(9'h0AA); push(9'h055); push(9'h00F); push(9'h0FC);
    wait_acc("par_wait", base + 5, 60);
    exp_b[4] = 8'hFC;
    check_pkt("par", base, 5, 1'b0);
    repeat (4) tick();
    check("par_pulse",   par_cnt - par0, 1);
    check("par_aligned", par_aligned - al0, 1);
    check("par_nocheck", par1_cnt - par10, 0);

    // Stray payload before a header, then a zero-length packet.
    base = acc_q.size(); frame0 = frame_cnt;
    push(9'h033); push(9'h100); push(9'h000);
    wait_acc("frm_wait", base + 2, 60);
    exp_b[0] = 8'h00; exp_b[1] = 8'h00;
    check_pkt("frm", base, 2, 1'b0);
    repeat (4) tick();
    check("frm_pulse", frame_cnt - frame0, 1);
    check("frm_addr",  {30'd0, bus0.pkt_addr}, 0);

    // Stalled header: flush on the 30th stalled cycle.
    base = acc_q.size(); soft0 = soft_cnt;
    bus0.dout_ready = 1'b0;
    push(9'h10D);
    wait_valid("tmo_valid", 40);
    for (int k = 1; k < 29; k++) tick();
    check("tmo_early", {31'd0, bus0.soft_reset}, 0);
    tick();
    check("tmo_soft",      {31'd0, bus0.soft_reset}, 1);
    check("tmo_valid_30",  {31'd0, bus0.dout_valid}, 1);
    tick();
    check("tmo_drop", {31'd0, bus0.dout_valid}, 0);
    repeat (3) tick();
    check("tmo_once",   soft_cnt - soft0, 1);
    check("tmo_noacc",  acc_q.size(), base);
    check("tmo_noread", {31'd0, bus0.fifo_read_enb}, 0);

    // Stall released on the 30th cycle: acceptance wins, no flush.
    base = acc_q.size(); soft0 = soft_cnt;
    push(9'h10D); push(9'h0AA); push(9'h055); push(9'h00F); push(9'h0FD);
    wait_valid("rel_valid", 40);
    for (int k = 1; k < 30; k++) tick();
    bus0.dout_ready = 1'b1;
    #1;
    check("rel_nosoft", {31'd0, bus0.soft_reset}, 0);
    wait_acc("rel_wait", base + 5, 60);
    exp_b[0] = 8'h0D; exp_b[1] = 8'hAA; exp_b[2] = 8'h55; exp_b[3] = 8'h0F; exp_b[4] = 8'hFD;
    check_pkt("rel", base, 5, 1'b0);
    repeat (3) tick();
    check("rel_soft", soft_cnt - soft0, 0);

    // FIFO underrun mid-packet: wait without reads or timeout.
    base = acc_q.size();
    push(9'h10D); push(9'h0AA);
    wait_acc("und_wait1", base + 2, 40);
    rd0 = rd_cnt; soft0 = soft_cnt;
    repeat (50) tick();
    check("und_reads", rd_cnt - rd0, 0);
    check("und_soft",  soft_cnt - soft0, 0);
    check("und_valid", {31'd0, bus0.dout_valid}, 0);
    push(9'h055); push(9'h00F); push(9'h0FD);
    wait_acc("und_wait2", base + 5, 60);
    check_pkt("und", base, 5, 1'b0);

    // Reset while payload byte 2 is being presented.
    bus0.dout_ready = 1'b0;
    push(9'h10D); push(9'h0AA); push(9'h055); push(9'h00F); push(9'h0FD);
    for (int j = 0; j < 2; j++) begin
      wait_valid($sformatf("mid_valid%0d", j), 40);
      bus0.dout_ready = 1'b1;
      tick();
      bus0.dout_ready = 1'b0;
    end
    wait_valid("mid_valid2", 40);
    check("mid_byte2", {24'd0, bus0.dout}, 32'h55);
    reset = 1'b1;
    tick();
    check("mid_valid", {31'd0, bus0.dout_valid}, 0);
    check("mid_dout",  {24'd0, bus0.dout}, 0);
    check("mid_first", {31'd0, bus0.dout_first}, 0);
    check("mid_last",  {31'd0, bus0.dout_last}, 0);
    check("mid_addr",  {30'd0, bus0.pkt_addr}, 0);
    check("mid_rd",    {31'd0, bus0.fifo_read_enb}, 0);
    check("mid_soft",  {31'd0, bus0.soft_reset}, 0);
    check("mid_errs",  {30'd0, bus0.frame_err, bus0.parity_err}, 0);
    reset = 1'b0;
    tick();

    // Fresh packet after reset: header 06 -> len 1, addr 2; parity 06^5A=5C.
    base = acc_q.size(); frame0 = frame_cnt; par0 = par_cnt;
    bus0.dout_ready = 1'b1;
    push(9'h106); push(9'h05A); push(9'h05C);
    wait_acc("new_wait", base + 3, 40);
    exp_b[0] = 8'h06; exp_b[1] = 8'h5A; exp_b[2] = 8'h5C;
    check_pkt("new", base, 3, 1'b1);
    repeat (3) tick();
    check("new_addr",  {30'd0, bus0.pkt_addr}, 2);
    check("new_frame", frame_cnt - frame0, 0);
    check("new_par",   par_cnt - par0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_out_drain.md
Name: router_out_drain

Overview:
- Reader side of the router output FIFO.
- Pulls 9-bit entries (bit 8 = header marker, bits 7:0 = byte) one at a time over the FIFO read interface.
- Checks packet framing and parity, then presents bytes to the destination port with a valid/ready handshake.
- Stalls with no consumer trigger a timeout that flushes the FIFO through soft_reset.
- One instance per router output port, placed between that port's FIFO and the external destination.

Parameters:
- TIMEOUT, 30: consecutive stalled cycles (dout_valid=1, dout_ready=0) before the packet is abandoned; legal range 1..255.
- PAR_CHECK, 1: 1 = compare the parity byte and pulse parity_err on mismatch; 0 = forward the parity byte unchecked.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  9  FIFO read data; valid the cycle after fifo_read_enb
- fifo_read_enb  out  1  FIFO read strobe, one cycle per entry
- soft_reset  out  1  one-cycle pulse that flushes the FIFO on timeout
- dout  out  8  byte to destination
- dout_valid  out  1  dout holds a byte
- dout_ready  in  1  destination accepts the byte when high with dout_valid
- dout_first  out  1  qualifies dout: header byte
- dout_last  out  1  qualifies dout: parity byte
- pkt_addr  out  2  destination address latched from the header
- frame_err  out  1  one-cycle pulse: framing violation
- parity_err  out  1  one-cycle pulse: parity mismatch

Behaviour:
- Packet format:
  - Header: bit8=1. len = byte[7:2] (0..63). addr = byte[1:0].
  - Then len payload bytes (bit8=0).
  - Then one parity byte (bit8=0) equal to the XOR of header and all payload bytes.
- Reset (sync, dominant over all other inputs): state=IDLE; all outputs 0; pkt_addr=0; internal length, parity and timeout counters cleared. Any in-flight packet is dropped silently.
- FSM states: IDLE, READ, CAPT, SEND.
- IDLE: when fifo_empty=0, go to READ. Expect a header.
- READ: assert fifo_read_enb for exactly one cycle only if fifo_empty=0, then go to CAPT. If fifo_empty=1, stay in READ with fifo_read_enb=0 (mid-packet underrun waits indefinitely, no timeout).
- CAPT: sample fifo_data_out into the dout register and classify it.
  - Header expected, bit8=1: latch len and addr, set parity acc = byte, set dout_first. Go to SEND.
  - Header expected, bit8=0: drop the byte, pulse frame_err, go to IDLE.
  - Payload expected, bit8=0: acc ^= byte, decrement remaining, go to SEND.
  - Payload or parity expected, bit8=1: drop the byte, pulse frame_err, abandon the packet, go to IDLE. The dropped byte is not re-parsed as a header.
  - Parity expected, bit8=0: set dout_last. If PAR_CHECK=1 and byte != acc, pulse parity_err in the same cycle dout_valid first rises. The byte is forwarded regardless.
- SEND: dout_valid=1. dout, dout_first and dout_last stay stable until dout_ready=1.
  - On acceptance: dout_valid drops next cycle; go to IDLE if the accepted byte was the parity byte, else READ.
- Latency: fifo_read_enb at cycle t, FIFO data sampled at end of t+1, dout_valid=1 at t+2. Peak throughput is one byte per 3 cycles with dout_ready held high.
- Only one FIFO read is ever outstanding. fifo_read_enb is never asserted while dout_valid=1 or while fifo_empty=1.
- Timeout:
  - Counter increments each SEND cycle with dout_ready=0 and clears on acceptance or on leaving SEND.
  - When the count reaches TIMEOUT: pulse soft_reset for one cycle, clear dout_valid, clear the counters, go to IDLE. The stalled byte is never delivered.
  - If dout_ready rises in the same cycle the count reaches TIMEOUT, acceptance wins and no soft_reset is issued.
- The length counter is 6 bits. len=0 means the parity byte follows the header directly, and the parity byte must equal the header byte.
- pkt_addr holds its value until the next valid header is captured.

Test Plan:
- Nominal: FIFO holds 1_0D, 0_AA, 0_55, 0_0F, 0_FD; dout_ready=1 -> dout sequence 0D(first), AA, 55, 0F, FD(last); pkt_addr=1; no error pulses; 3 cycles per byte; fifo_read_enb exactly 5 pulses.
- Parity error: same packet with last entry 0_FC, PAR_CHECK=1 -> FC forwarded with dout_last; one parity_err pulse aligned with its dout_valid rise. With PAR_CHECK=0 -> no pulse.
- Framing: FIFO holds 0_33 then 1_00, 0_00 -> 33 dropped with one frame_err pulse; zero-length packet 00(first), 00(last) delivered; pkt_addr=0.
- Backpressure/timeout: header delivered, dout_ready held 0 for 30 cycles -> soft_reset pulses once on the 30th stalled cycle, dout_valid=0 next cycle, state IDLE. Repeat releasing dout_ready on cycle 30 -> byte accepted, no soft_reset.
- Underrun: header and one of three payload bytes present, fifo_empty=1 for 50 cycles -> no fifo_read_enb, no soft_reset. Remaining bytes written later -> packet completes correctly.
- Reset mid-packet: assert reset during SEND of payload byte 2 -> next cycle all outputs 0. A new packet with header 1_06 is then parsed from scratch with pkt_addr=2.
